cpu_program_driver: RTL and testbench
=====================================

Name: cpu_program_driver

Overview:
Upstream stimulus stage for the single-cycle processor under test. It holds the test program in a local word memory loaded over a valid/ready port. It drives the CPU reset and serves the instruction combinationally from the CPU's PC in the same cycle. It detects program end (PC self-loop) or timeout and reports status and cycle count to the bench.

Parameters:
ADDR_W, 8, program memory word-address width (2**ADDR_W words of 32 bits)
RST_CYCLES, 2, cycles cpu_reset is held high after start (>=1)
HALT_REPEAT, 4, consecutive identical-PC RUN cycles that signal halt (>=2)
MAX_CYCLES, 1024, RUN-cycle limit before timeout

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset of this block
load_valid  in  1  program word write request
load_ready  out  1  write accepted when valid&ready
load_addr  in  ADDR_W  word index
load_data  in  32  instruction word
start  in  1  begin a run (single-cycle pulse)
cpu_pc  in  32  PC from CPU
cpu_reset  out  1  reset to CPU
cpu_instruction  out  32  instruction to CPU
busy  out  1  high in HOLD_RST/RUN
done  out  1  run finished (DONE state)
timeout  out  1  run ended by MAX_CYCLES
pc_error  out  1  sticky: misaligned or out-of-range PC seen in RUN
cycle_count  out  32  RUN cycles in current/last run

Behaviour:
- One clock clk; reset synchronous, active-high. Reset values: state IDLE, cpu_reset=1, cpu_instruction=0, load_ready=1, busy=0, done=0, timeout=0, pc_error=0, cycle_count=0. Program memory is not reset; contents survive reset.
- States: IDLE, HOLD_RST, RUN, DONE.
- IDLE: load_ready=1; on valid&ready, mem[load_addr]<=load_data at the clock edge. start -> HOLD_RST. start and load_valid in the same cycle: write happens and start is taken.
- HOLD_RST: cpu_reset=1 for exactly RST_CYCLES cycles, then RUN. On entry: cycle_count, timeout, pc_error and halt tracker cleared.
- RUN: cpu_reset=0. cpu_instruction = mem[cpu_pc[ADDR_W+1:2]], combinational, zero latency. Each RUN cycle increments cycle_count.
- PC bad: cpu_pc[1:0]!=0 or cpu_pc[31:ADDR_W+2]!=0. Then cpu_instruction=32'h0000_0000 (NOP) and pc_error<=1. The run continues.
- Halt tracker: prev_pc and repeat counter. The first RUN cycle sets repeat=1. cpu_pc==prev_pc increments repeat; otherwise repeat resets to 1. repeat reaching HALT_REPEAT -> DONE next cycle.
- Timeout: cycle_count reaching MAX_CYCLES -> DONE with timeout=1. Halt and timeout in the same cycle: halt wins, timeout=0.
- DONE: done=1, cpu_reset=1, cpu_instruction=0, load_ready=1. Loads are allowed. Status and count hold. start -> HOLD_RST (re-run).
- load_ready=0 in HOLD_RST/RUN; load_valid is ignored there.
- start outside IDLE/DONE is ignored.
- cycle_count saturates at 2**32-1.
- reset in any state (including mid-RUN) -> IDLE next cycle with reset values.
- Unloaded words read X in simulation; the bench loads every word it uses.

Decomposition:
- Package cpu_tb_pkg: drv_state_t enum {IDLE,HOLD_RST,RUN,DONE}; constant NOP_INSTR=32'h0; constant WORD_W=32.
- Sub-module program_mem: 2**ADDR_W x 32, one synchronous write port, one asynchronous read port, no reset.
- The FSM, halt tracker and counters stay in cpu_program_driver.

Test Plan:
- Load 3 words (0x20080005, 0x21080001, 0x1000FFFF at idx 0..2), pulse start. Required: cpu_reset high exactly 2 cycles, then low. With cpu_pc=0, cpu_instruction=0x20080005 in the same cycle; with cpu_pc=8, 0x1000FFFF.
- RUN with PC sequence 0,4,8,8,8,8 (HALT_REPEAT=4). Required: done=1 and cpu_reset=1 in the cycle after the 6th RUN cycle, cycle_count=6, timeout=0.
- MAX_CYCLES=16, PC incrementing by 4 every cycle. Required: done=1, timeout=1, cycle_count=16.
- In RUN, cpu_pc=0x0000_0402 one cycle, then 0x0000_0404. Required: cpu_instruction=0 for the bad cycle, pc_error=1 from the next cycle and staying set, run continues normally.
- reset asserted in RUN cycle 3. Required: next cycle IDLE, cpu_reset=1, busy=0, cycle_count=0. Then start and PC=0 gives the same instruction as before (memory kept).
- load_valid with load_addr=0, data 0xDEADBEEF during RUN. Required: load_ready=0 and mem[0] unchanged. The same load in DONE is accepted, and the next run reads 0xDEADBEEF at PC 0.

Source files
------------

// File: rtl/cpu_program_driver_pkg.sv
// Shared types and constants for the CPU program driver slice.
// State encoding, word width and the NOP word served outside RUN.
package cpu_tb_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    HOLD_RST,
    RUN,
    DONE
  } drv_state_t;

endpackage

// File: rtl/cpu_program_driver_if.sv
// Program load, run control, CPU fetch and status signals of the driver.
// The bench holds the master side; the driver holds the slave side.
interface cpu_program_driver_if #(
  parameter int ADDR_W = 8
) ();
  import cpu_tb_pkg::*;

  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [WORD_W-1:0] load_data;
  logic              start;
  logic [31:0]       cpu_pc;
  logic              cpu_reset;
  logic [WORD_W-1:0] cpu_instruction;
  logic              busy;
  logic              done;
  logic              timeout;
  logic              pc_error;
  logic [31:0]       cycle_count;

  modport slave (
    input  load_valid, load_addr, load_data, start, cpu_pc,
    output load_ready, cpu_reset, cpu_instruction, busy, done, timeout,
           pc_error, cycle_count
  );

  modport master (
    output load_valid, load_addr, load_data, start, cpu_pc,
    input  load_ready, cpu_reset, cpu_instruction, busy, done, timeout,
           pc_error, cycle_count
  );
endinterface

// File: rtl/cpu_program_driver_program_mem.sv
// Program word store: synchronous write, zero-latency asynchronous read.
// No backpressure; contents are deliberately not reset.
module program_mem
  import cpu_tb_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cpu_program_driver.sv
// Loads a test program, holds the CPU in reset, serves fetches same-cycle from cpu_pc,
// and ends the run on PC self-loop or cycle limit; loads are refused while busy.
module cpu_program_driver
  import cpu_tb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int RST_CYCLES  = 2,
  parameter int HALT_REPEAT = 4,
  parameter int MAX_CYCLES  = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  cpu_program_driver_if.slave  bus
);

  localparam int HOLD_W = $clog2(RST_CYCLES + 1);
  localparam int REP_W  = $clog2(HALT_REPEAT + 1);

  drv_state_t        state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [31:0]       prev_pc;
  logic [REP_W-1:0]  rep_cnt, rep_nxt;
  logic              first_run;
  logic [31:0]       cycle_cnt, cnt_inc;
  logic              timeout_r, pc_error_r;
  logic              pc_bad, halt_hit, limit_hit, load_ok;
  logic [WORD_W-1:0] mem_rd;

  program_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .wr_en   (bus.load_valid & load_ok),
    .wr_addr (bus.load_addr),
    .wr_data (bus.load_data),
    .rd_addr (bus.cpu_pc[ADDR_W+1:2]),
    .rd_data (mem_rd)
  );

  always_comb begin
    pc_bad    = (bus.cpu_pc[1:0] != 2'b00) || (bus.cpu_pc[31:ADDR_W+2] != '0);
    rep_nxt   = (first_run || bus.cpu_pc != prev_pc) ? REP_W'(1) : rep_cnt + 1'b1;
    cnt_inc   = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + 32'd1;
    halt_hit  = (rep_nxt == REP_W'(HALT_REPEAT));
    limit_hit = (cnt_inc == 32'(MAX_CYCLES));
    load_ok   = (state == IDLE) || (state == DONE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nxt = HOLD_RST;
      HOLD_RST:   if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) state_nxt = RUN;
      RUN:        if (halt_hit || limit_hit) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt   <= '0;
      prev_pc    <= '0;
      rep_cnt    <= '0;
      first_run  <= 1'b0;
      cycle_cnt  <= '0;
      timeout_r  <= 1'b0;
      pc_error_r <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // Status is cleared as the run is launched so HOLD_RST already shows a clean slate.
          if (bus.start) begin
            hold_cnt   <= '0;
            rep_cnt    <= '0;
            first_run  <= 1'b1;
            cycle_cnt  <= '0;
            timeout_r  <= 1'b0;
            pc_error_r <= 1'b0;
          end
        end
        HOLD_RST: hold_cnt <= hold_cnt + 1'b1;
        RUN: begin
          cycle_cnt <= cnt_inc;
          prev_pc   <= bus.cpu_pc;
          rep_cnt   <= rep_nxt;
          first_run <= 1'b0;
          if (pc_bad) pc_error_r <= 1'b1;
          // A halt on the limit cycle is a clean end, not a timeout.
          if (limit_hit && !halt_hit) timeout_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.cpu_reset       = (state != RUN);
    bus.cpu_instruction = (state == RUN && !pc_bad) ? mem_rd : NOP_INSTR;
    bus.load_ready      = load_ok;
    bus.busy            = (state == HOLD_RST) || (state == RUN);
    bus.done            = (state == DONE);
    bus.timeout         = timeout_r;
    bus.pc_error        = pc_error_r;
    bus.cycle_count     = cycle_cnt;
  end

endmodule

// File: tb/tb_cpu_program_driver.sv
// Randomised bench for cpu_program_driver: a queue-based run model is compared every cycle,
// with hand-computed expectations for the directed scenarios.
module tb_cpu_program_driver;

  localparam int AW = 8;
  localparam int RC = 2;
  localparam int HR = 4;
  localparam int MC = 16;
  localparam int MD_IDLE = 0, MD_HOLD = 1, MD_RUN = 2, MD_DONE = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_program_driver_if #(.ADDR_W(AW)) bus ();

  cpu_program_driver #(
    .ADDR_W(AW), .RST_CYCLES(RC), .HALT_REPEAT(HR), .MAX_CYCLES(MC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is just the list of PCs seen while running.
  logic [31:0] m_mem [256];
  logic [31:0] m_pcs [$];
  int          m_mode = MD_IDLE;
  int          m_hold_left = 0;
  bit          m_to = 0, m_pe = 0, m_valid = 0;

  function automatic bit bad_pc(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc >= 32'(4 * (1 << AW)));
  endfunction

  function automatic bit halted();
    int n = m_pcs.size();
    if (n < HR) return 0;
    for (int i = 1; i < HR; i++)
      if (m_pcs[n-1-i] != m_pcs[n-1]) return 0;
    return 1;
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_mode = MD_IDLE; m_pcs.delete(); m_to = 0; m_pe = 0; m_valid = 1;
    end else if (m_valid) begin
      case (m_mode)
        MD_IDLE, MD_DONE: begin
          if (bus.load_valid) m_mem[int'(bus.load_addr)] = bus.load_data;
          if (bus.start) begin
            m_mode = MD_HOLD; m_hold_left = RC; m_pcs.delete(); m_to = 0; m_pe = 0;
          end
        end
        MD_HOLD: begin
          m_hold_left--;
          if (m_hold_left == 0) m_mode = MD_RUN;
        end
        default: begin
          m_pcs.push_back(bus.cpu_pc);
          if (bad_pc(bus.cpu_pc)) m_pe = 1;
          if (halted()) m_mode = MD_DONE;
          else if (m_pcs.size() == MC) begin m_mode = MD_DONE; m_to = 1; end
        end
      endcase
    end
  end

  initial forever begin
    logic [31:0] e_instr;
    @(negedge clk);
    if (m_valid) begin
      e_instr = 32'h0;
      if (m_mode == MD_RUN && !bad_pc(bus.cpu_pc)) e_instr = m_mem[int'((bus.cpu_pc / 4) % 256)];
      chk("cpu_reset",   32'(bus.cpu_reset),  32'(m_mode != MD_RUN));
      chk("load_ready",  32'(bus.load_ready), 32'(m_mode == MD_IDLE || m_mode == MD_DONE));
      chk("busy",        32'(bus.busy),       32'(m_mode == MD_HOLD || m_mode == MD_RUN));
      chk("done",        32'(bus.done),       32'(m_mode == MD_DONE));
      chk("timeout",     32'(bus.timeout),    32'(m_to));
      chk("pc_error",    32'(bus.pc_error),   32'(m_pe));
      chk("cycle_count", bus.cycle_count,     32'(m_pcs.size()));
      chk("instruction", bus.cpu_instruction, e_instr);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] pcq [$];
  logic [31:0] got_instr [$];
  logic        got_rst [$];
  logic        got_pe [$];
  bit          noise = 0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load_word(input int idx, input logic [31:0] d);
    bus.load_valid = 1'b1; bus.load_addr = 8'(idx); bus.load_data = d;
    step();
    bus.load_valid = 1'b0;
  endtask

  task automatic pulse_start(input bit with_load, input int a, input logic [31:0] d);
    bus.start = 1'b1; bus.load_valid = with_load; bus.load_addr = 8'(a); bus.load_data = d;
    step();
    bus.start = 1'b0; bus.load_valid = 1'b0;
    @(negedge clk); chk("hold_cpu_reset_c1", 32'(bus.cpu_reset), 32'd1);
    step();
    @(negedge clk); chk("hold_cpu_reset_c2", 32'(bus.cpu_reset), 32'd1);
    step();
  endtask

  function automatic logic [31:0] rand_pc(input logic [31:0] last);
    int r = $urandom_range(0, 9);
    if (r < 4) return last;
    if (r < 8) return 32'($urandom_range(0, 15) * 4);
    if (r == 8) return last + 32'd2;
    return $urandom;
  endfunction

  task automatic run_pcs(input int max_cyc);
    logic [31:0] pc = 32'h0;
    int k = 0;
    got_instr.delete(); got_rst.delete(); got_pe.delete();
    while (m_mode == MD_RUN && k < max_cyc) begin
      if (pcq.size() > 0) pc = pcq.pop_front();
      else pc = rand_pc(pc);
      bus.cpu_pc = pc;
      if (noise) begin
        bus.load_valid = ($urandom_range(0, 2) == 0);
        bus.load_addr  = 8'($urandom_range(0, 15));
        bus.load_data  = $urandom;
        bus.start      = ($urandom_range(0, 4) == 0);
      end
      @(negedge clk);
      got_instr.push_back(bus.cpu_instruction);
      got_rst.push_back(bus.cpu_reset);
      got_pe.push_back(bus.pc_error);
      step();
      k++;
    end
    bus.load_valid = 1'b0; bus.start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.load_valid = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    bus.start = 1'b0; bus.cpu_pc = '0;
    step();
    @(negedge clk);
    chk("rst_cpu_reset",  32'(bus.cpu_reset),  32'd1);
    chk("rst_load_ready", 32'(bus.load_ready), 32'd1);
    chk("rst_busy",       32'(bus.busy),       32'd0);
    chk("rst_done",       32'(bus.done),       32'd0);
    chk("rst_timeout",    32'(bus.timeout),    32'd0);
    chk("rst_pc_error",   32'(bus.pc_error),   32'd0);
    chk("rst_cycle_cnt",  bus.cycle_count,     32'd0);
    chk("rst_instr",      bus.cpu_instruction, 32'd0);
    step();
    reset = 1'b0;

    for (int i = 0; i < 256; i++) load_word(i, $urandom);
    load_word(0, 32'h2008_0005);
    load_word(1, 32'h2108_0001);
    load_word(2, 32'h1000_FFFF);

    // Self-loop halt after the fourth identical PC.
    pulse_start(0, 0, 0);
    pcq = '{32'd0, 32'd4, 32'd8, 32'd8, 32'd8, 32'd8};
    run_pcs(20);
    chk("halt_first_run_rst", 32'(got_rst[0]), 32'd0);
    chk("halt_instr_pc0",     got_instr[0],    32'h2008_0005);
    chk("halt_instr_pc8",     got_instr[2],    32'h1000_FFFF);
    chk("halt_run_len",       32'(got_instr.size()), 32'd6);
    @(negedge clk);
    chk("halt_done",      32'(bus.done),      32'd1);
    chk("halt_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    chk("halt_count",     bus.cycle_count,    32'd6);
    chk("halt_timeout",   32'(bus.timeout),   32'd0);

    // Cycle limit with a strictly advancing PC.
    pulse_start(0, 0, 0);
    for (int i = 0; i < 20; i++) pcq.push_back(32'(4 * i));
    run_pcs(30);
    pcq.delete();
    @(negedge clk);
    chk("to_done",    32'(bus.done),    32'd1);
    chk("to_timeout", 32'(bus.timeout), 32'd1);
    chk("to_count",   bus.cycle_count,  32'd16);

    // Misaligned then out-of-range PC: NOP served, sticky error, run continues.
    pulse_start(0, 0, 0);
    pcq = '{32'd0, 32'h402, 32'h404, 32'd4, 32'd8, 32'd8, 32'd8, 32'd8};
    run_pcs(20);
    chk("bad_instr_nop",  got_instr[1],     32'd0);
    chk("bad_pe_before",  32'(got_pe[1]),   32'd0);
    chk("bad_pe_after",   32'(got_pe[2]),   32'd1);
    chk("bad_instr_pc4",  got_instr[3],     32'h2108_0001);
    @(negedge clk);
    chk("bad_pe_sticky",  32'(bus.pc_error), 32'd1);
    chk("bad_count",      bus.cycle_count,   32'd8);

    // Reset in the third RUN cycle; memory survives.
    pulse_start(0, 0, 0);
    pcq = '{32'd0, 32'd4};
    run_pcs(2);
    bus.cpu_pc = 32'd8; reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy",      32'(bus.busy),      32'd0);
    chk("midrst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    chk("midrst_count",     bus.cycle_count,    32'd0);
    chk("midrst_done",      32'(bus.done),      32'd0);
    pulse_start(0, 0, 0);
    pcq = '{32'd0, 32'd0, 32'd0, 32'd0};
    run_pcs(10);
    chk("midrst_mem_kept", got_instr[0], 32'h2008_0005);

    // Loads are refused while running and accepted in DONE.
    pulse_start(0, 0, 0);
    bus.cpu_pc = 32'd0;
    bus.load_valid = 1'b1; bus.load_addr = 8'd0; bus.load_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("run_load_ready", 32'(bus.load_ready), 32'd0);
    step();
    bus.load_valid = 1'b0;
    pcq = '{32'd0, 32'd0, 32'd0};
    run_pcs(10);
    chk("run_load_ignored", got_instr[0], 32'h2008_0005);
    bus.load_valid = 1'b1; bus.load_addr = 8'd0; bus.load_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("done_load_ready", 32'(bus.load_ready), 32'd1);
    step();
    bus.load_valid = 1'b0;
    pulse_start(0, 0, 0);
    pcq = '{32'd0, 32'd4, 32'd4, 32'd4, 32'd4};
    run_pcs(10);
    chk("done_load_taken", got_instr[0], 32'hDEAD_BEEF);

    // Random runs with load/start noise, start+load collisions and occasional mid-run reset.
    for (int r = 0; r < 14; r++) begin
      if ($urandom_range(0, 1) == 1) load_word($urandom_range(0, 15), $urandom);
      pulse_start($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom);
      noise = 1;
      if (r % 4 == 3) begin
        run_pcs(3);
        noise = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
      end else begin
        run_pcs(MC + 4);
        noise = 0;
        @(negedge clk);
        chk("rand_run_done", 32'(bus.done), 32'd1);
      end
    end

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
